// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit CPU control path: opcodes, control-word
// bit indices, phase positions in the timing vector and sequencer states.
package cpu8_pkg;

    localparam int CW_W  = 14;
    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPC_W-1:0] OP_STA = 4'h4;
    localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h7;
    localparam logic [OPC_W-1:0] OP_OUT = 4'h8;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    localparam int CW_PC_OE   = 0;
    localparam int CW_MAR_LD  = 1;
    localparam int CW_RAM_RD  = 2;
    localparam int CW_IR_LD   = 3;
    localparam int CW_PC_INC  = 4;
    localparam int CW_IR_OE   = 5;
    localparam int CW_A_LD    = 6;
    localparam int CW_B_LD    = 7;
    localparam int CW_ALU_SUB = 8;
    localparam int CW_ALU_OE  = 9;
    localparam int CW_RAM_WR  = 10;
    localparam int CW_A_OE    = 11;
    localparam int CW_PC_LD   = 12;
    localparam int CW_OUT_LD  = 13;

    // Bit position of each phase in the timing vector; T0 is the generator's reset phase.
    localparam int T0_BIT = 7;
    localparam int T1_BIT = 0;
    localparam int T2_BIT = 1;
    localparam int T3_BIT = 2;
    localparam int T4_BIT = 3;
    localparam int T5_BIT = 4;
    localparam int T6_BIT = 5;
    localparam int T7_BIT = 6;

    localparam logic [2:0] PH_T0 = 3'd0;
    localparam logic [2:0] PH_T3 = 3'd3;
    localparam logic [2:0] PH_T7 = 3'd7;

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_RUN   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } seq_state_t;

    // Phase number of a one-hot vector; non one-hot inputs are screened separately.
    function automatic logic [2:0] phase_idx(input logic [7:0] sig);
        logic [2:0] idx;
        idx = 3'd0;
        if (sig[T1_BIT]) idx = 3'd1;
        if (sig[T2_BIT]) idx = 3'd2;
        if (sig[T3_BIT]) idx = 3'd3;
        if (sig[T4_BIT]) idx = 3'd4;
        if (sig[T5_BIT]) idx = 3'd5;
        if (sig[T6_BIT]) idx = 3'd6;
        if (sig[T7_BIT]) idx = 3'd7;
        return idx;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational microcode ROM: (phase, opcode, zf) -> control word plus an
// undefined-opcode flag raised only on the T3 decode step.
module ctrl_decode
    import cpu8_pkg::*;
(
    input  logic [2:0]       i_phase,
    input  logic [OPC_W-1:0] i_opcode,
    input  logic             i_zf,
    output logic [CW_W-1:0]  o_cw,
    output logic             o_illegal
);

    always_comb begin
        o_cw      = '0;
        o_illegal = 1'b0;
        case (i_phase)
            3'd0: begin
                o_cw[CW_PC_OE]  = 1'b1;
                o_cw[CW_MAR_LD] = 1'b1;
            end
            3'd1: begin
                o_cw[CW_RAM_RD] = 1'b1;
                o_cw[CW_IR_LD]  = 1'b1;
            end
            3'd2: o_cw[CW_PC_INC] = 1'b1;
            3'd3: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        o_cw[CW_IR_OE]  = 1'b1;
                        o_cw[CW_MAR_LD] = 1'b1;
                    end
                    OP_LDI: begin
                        o_cw[CW_IR_OE] = 1'b1;
                        o_cw[CW_A_LD]  = 1'b1;
                    end
                    OP_JMP: begin
                        o_cw[CW_IR_OE] = 1'b1;
                        o_cw[CW_PC_LD] = 1'b1;
                    end
                    OP_JZ: begin
                        o_cw[CW_IR_OE] = i_zf;
                        o_cw[CW_PC_LD] = i_zf;
                    end
                    OP_OUT: begin
                        o_cw[CW_A_OE]   = 1'b1;
                        o_cw[CW_OUT_LD] = 1'b1;
                    end
                    OP_NOP, OP_HLT: o_cw = '0;
                    default: o_illegal = 1'b1;
                endcase
            end
            3'd4: begin
                case (i_opcode)
                    OP_LDA: begin
                        o_cw[CW_RAM_RD] = 1'b1;
                        o_cw[CW_A_LD]   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        o_cw[CW_RAM_RD] = 1'b1;
                        o_cw[CW_B_LD]   = 1'b1;
                    end
                    OP_STA: begin
                        o_cw[CW_A_OE]   = 1'b1;
                        o_cw[CW_RAM_WR] = 1'b1;
                    end
                    default: o_cw = '0;
                endcase
            end
            3'd5: begin
                if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
                    o_cw[CW_ALU_OE]  = 1'b1;
                    o_cw[CW_A_LD]    = 1'b1;
                    o_cw[CW_ALU_SUB] = (i_opcode == OP_SUB);
                end
            end
            default: o_cw = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Control sequencer: phase checker, run/halt/fault state and registered control word.
// Optional single-step mode (i_step input, WAIT state) is built when CTRL_STEP_EN is defined.
module ctrl_sequencer
    import cpu8_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_signals,
    input  logic [OPC_W-1:0] i_opcode,
    input  logic             i_zf,
`ifdef CTRL_STEP_EN
    input  logic             i_step,
`endif
    output logic [CW_W-1:0]  o_ctrl,
    output logic             o_halted,
    output logic             o_phase_err,
    output logic             o_illegal_op
);

    seq_state_t       r_state;
    logic [OPC_W-1:0] r_op_q;
    logic [2:0]       r_prev_phase;
`ifdef CTRL_STEP_EN
    logic             r_armed;
`endif

    logic             w_onehot;
    logic [2:0]       w_idx;
    logic             w_seq_ok;
    logic [OPC_W-1:0] w_op;
    logic [CW_W-1:0]  w_cw;
    logic             w_illegal;

    assign w_onehot = $onehot(i_signals);
    assign w_idx    = phase_idx(i_signals);
    assign w_seq_ok = w_onehot && (w_idx == r_prev_phase + 3'd1);
    // T3 decodes straight from IR; later steps must not see IR changing underneath.
    assign w_op     = (w_idx == PH_T3) ? i_opcode : r_op_q;

    ctrl_decode u_decode (
        .i_phase   (w_idx),
        .i_opcode  (w_op),
        .i_zf      (i_zf),
        .o_cw      (w_cw),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_SYNC;
            r_op_q       <= '0;
            r_prev_phase <= '0;
            o_ctrl       <= '0;
            o_halted     <= 1'b0;
            o_phase_err  <= 1'b0;
            o_illegal_op <= 1'b0;
`ifdef CTRL_STEP_EN
            r_armed      <= 1'b0;
`endif
        end else begin
            o_illegal_op <= 1'b0;
            o_ctrl       <= '0;
            case (r_state)
                ST_SYNC: begin
                    if (i_signals == (8'h01 << T0_BIT)) begin
                        r_state      <= ST_RUN;
                        r_prev_phase <= PH_T0;
                        o_ctrl       <= w_cw;
                    end
                end
                ST_RUN: begin
                    if (!w_seq_ok) begin
                        r_state     <= ST_FAULT;
                        o_phase_err <= 1'b1;
                    end else begin
                        r_prev_phase <= w_idx;
                        if (w_idx == PH_T3) begin
                            r_op_q       <= i_opcode;
                            o_illegal_op <= w_illegal;
                        end
                        if (w_idx == PH_T3 && i_opcode == OP_HLT) begin
                            r_state  <= ST_HALT;
                            o_halted <= 1'b1;
                        end else begin
                            o_ctrl <= w_cw;
                        end
`ifdef CTRL_STEP_EN
                        if (w_idx == PH_T7)
                            r_state <= ST_WAIT;
`endif
                    end
                end
`ifdef CTRL_STEP_EN
                ST_WAIT: begin
                    if (!w_seq_ok) begin
                        r_state     <= ST_FAULT;
                        o_phase_err <= 1'b1;
                    end else begin
                        r_prev_phase <= w_idx;
                        if (i_step)
                            r_armed <= 1'b1;
                        // Only a step seen in an earlier WAIT cycle releases this T0.
                        if (w_idx == PH_T0 && r_armed) begin
                            r_state <= ST_RUN;
                            r_armed <= 1'b0;
                            o_ctrl  <= w_cw;
                        end
                    end
                end
`endif
                ST_HALT:  o_halted    <= 1'b1;
                ST_FAULT: o_phase_err <= 1'b1;
                default: begin
                    r_state     <= ST_FAULT;
                    o_phase_err <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed, table-driven bench for ctrl_sequencer; covers the step build when CTRL_STEP_EN is defined.
module tb_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  signals;
    logic [3:0]  opcode;
    logic        zf;
    logic        step;
    logic [13:0] ctrl;
    logic        halted, phase_err, illegal_op;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic        rst;
        logic [7:0]  sig;
        logic [3:0]  op;
        logic        zf;
        logic        step;
        logic [13:0] ctrl;
        logic        h;
        logic        pe;
        logic        il;
    } vec_t;

    vec_t tv[$];

    ctrl_sequencer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_signals    (signals),
        .i_opcode     (opcode),
        .i_zf         (zf),
`ifdef CTRL_STEP_EN
        .i_step       (step),
`endif
        .o_ctrl       (ctrl),
        .o_halted     (halted),
        .o_phase_err  (phase_err),
        .o_illegal_op (illegal_op)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] ph(input int k);
        logic [7:0] one;
        one = 8'h01;
        return (k == 0) ? 8'h80 : (one << (k - 1));
    endfunction

    function automatic void add(input string n, input logic r, input logic [7:0] s,
                                input logic [3:0] o, input logic z, input logic st,
                                input logic [13:0] c, input logic h, input logic pe,
                                input logic il);
        vec_t v;
        v.name = n; v.rst = r; v.sig = s; v.op = o; v.zf = z; v.step = st;
        v.ctrl = c; v.h = h; v.pe = pe; v.il = il;
        tv.push_back(v);
    endfunction

    function automatic void add_rst();
        add("reset", 1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic void add_ring(input string n, input logic [3:0] o, input logic z,
                                     input logic [13:0] w0, input logic [13:0] w1,
                                     input logic [13:0] w2, input logic [13:0] w3,
                                     input logic [13:0] w4, input logic [13:0] w5,
                                     input logic [13:0] w6, input logic [13:0] w7);
        logic [13:0] w [8];
        w = '{w0, w1, w2, w3, w4, w5, w6, w7};
        for (int k = 0; k < 8; k++)
            add($sformatf("%s_T%0d", n, k), 1'b0, ph(k), o, z, 1'b0, w[k], 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string n, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", n, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; signals = v.sig; opcode = v.op; zf = v.zf; step = v.step;
        @(posedge clk);
        #1;
        chk({v.name, ".ctrl"},       ctrl,                v.ctrl);
        chk({v.name, ".halted"},     {13'h0, halted},     {13'h0, v.h});
        chk({v.name, ".phase_err"},  {13'h0, phase_err},  {13'h0, v.pe});
        chk({v.name, ".illegal_op"}, {13'h0, illegal_op}, {13'h0, v.il});
    endtask

    task automatic cyc(input string n, input logic [7:0] s, input logic [3:0] o,
                       input logic st, input logic [13:0] c, input logic h, input logic pe);
        vec_t v;
        v.name = n; v.rst = 1'b0; v.sig = s; v.op = o; v.zf = 1'b0; v.step = st;
        v.ctrl = c; v.h = h; v.pe = pe; v.il = 1'b0;
        apply(v);
    endtask

    initial begin
        rst = 1'b1; signals = 8'h00; opcode = 4'h0; zf = 1'b0; step = 1'b0;

        // Reset and SYNC waiting on non-T0 / zero vectors.
        add_rst();
        add("sync_T3",   1'b0, 8'h04, 4'h5, 1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 1'b0);
        add("sync_zero", 1'b0, 8'h00, 4'h5, 1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 1'b0);
        add("sync_multi",1'b0, 8'h81, 4'h5, 1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 1'b0);
        add_ring("ldi", 4'h5, 1'b0, 14'h0003, 14'h000C, 14'h0010, 14'h0060, 0, 0, 0, 0);
        add_rst();
        add_ring("sub", 4'h3, 1'b0, 14'h0003, 14'h000C, 14'h0010, 14'h0022, 14'h0084, 14'h0340, 0, 0);
        add_rst();
        add_ring("add", 4'h2, 1'b0, 14'h0003, 14'h000C, 14'h0010, 14'h0022, 14'h0084, 14'h0240, 0, 0);
        add_rst();
        add_ring("lda", 4'h1, 1'b0, 14'h0003, 14'h000C, 14'h0010, 14'h0022, 14'h0044, 0, 0, 0);
        add_rst();
        add_ring("sta", 4'h4, 1'b0, 14'h0003, 14'h000C, 14'h0010, 14'h0022, 14'h0C00, 0, 0, 0);
        add_rst();
        add_ring("jz1", 4'h7, 1'b1, 14'h0003, 14'h000C, 14'h0010, 14'h1020, 0, 0, 0, 0);
        add_rst();
        add_ring("jz0", 4'h7, 1'b0, 14'h0003, 14'h000C, 14'h0010, 14'h0000, 0, 0, 0, 0);
        add_rst();
        add_ring("jmp", 4'h6, 1'b0, 14'h0003, 14'h000C, 14'h0010, 14'h1020, 0, 0, 0, 0);
        add_rst();
        add_ring("out", 4'h8, 1'b0, 14'h0003, 14'h000C, 14'h0010, 14'h2800, 0, 0, 0, 0);

        // IR changes after T3: T4/T5 must follow the latched SUB.
        add_rst();
        add("opq_T0", 1'b0, ph(0), 4'h3, 1'b0, 1'b0, 14'h0003, 1'b0, 1'b0, 1'b0);
        add("opq_T1", 1'b0, ph(1), 4'h3, 1'b0, 1'b0, 14'h000C, 1'b0, 1'b0, 1'b0);
        add("opq_T2", 1'b0, ph(2), 4'h3, 1'b0, 1'b0, 14'h0010, 1'b0, 1'b0, 1'b0);
        add("opq_T3", 1'b0, ph(3), 4'h3, 1'b0, 1'b0, 14'h0022, 1'b0, 1'b0, 1'b0);
        add("opq_T4", 1'b0, ph(4), 4'h5, 1'b0, 1'b0, 14'h0084, 1'b0, 1'b0, 1'b0);
        add("opq_T5", 1'b0, ph(5), 4'h0, 1'b0, 1'b0, 14'h0340, 1'b0, 1'b0, 1'b0);

        // Undefined opcode: one-cycle illegal_op after T3.
        add_rst();
        add("ill_T0", 1'b0, ph(0), 4'hA, 1'b0, 1'b0, 14'h0003, 1'b0, 1'b0, 1'b0);
        add("ill_T1", 1'b0, ph(1), 4'hA, 1'b0, 1'b0, 14'h000C, 1'b0, 1'b0, 1'b0);
        add("ill_T2", 1'b0, ph(2), 4'hA, 1'b0, 1'b0, 14'h0010, 1'b0, 1'b0, 1'b0);
        add("ill_T3", 1'b0, ph(3), 4'hA, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b1);
        add("ill_T4", 1'b0, ph(4), 4'hA, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0);
        add("ill_T5", 1'b0, ph(5), 4'hA, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0);

        // Skipped phase (T2 -> T4) faults, sticky until reset.
        add_rst();
        add("skip_T0", 1'b0, ph(0), 4'h5, 1'b0, 1'b0, 14'h0003, 1'b0, 1'b0, 1'b0);
        add("skip_T1", 1'b0, ph(1), 4'h5, 1'b0, 1'b0, 14'h000C, 1'b0, 1'b0, 1'b0);
        add("skip_T2", 1'b0, ph(2), 4'h5, 1'b0, 1'b0, 14'h0010, 1'b0, 1'b0, 1'b0);
        add("skip_T4", 1'b0, ph(4), 4'h2, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0);
        add("skip_T5", 1'b0, ph(5), 4'h2, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0);
        add("skip_T0b",1'b0, ph(0), 4'h5, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0);
        add_rst();
        // Zero vector mid-ring.
        add("zero_T0", 1'b0, ph(0), 4'h5, 1'b0, 1'b0, 14'h0003, 1'b0, 1'b0, 1'b0);
        add("zero_T1", 1'b0, ph(1), 4'h5, 1'b0, 1'b0, 14'h000C, 1'b0, 1'b0, 1'b0);
        add("zero_00", 1'b0, 8'h00, 4'h5, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0);
        add("zero_T3", 1'b0, ph(3), 4'h5, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0);
        add_rst();
        // Multi-hot mid-ring.
        add("mh_T0", 1'b0, ph(0), 4'h5, 1'b0, 1'b0, 14'h0003, 1'b0, 1'b0, 1'b0);
        add("mh_T1", 1'b0, 8'h03, 4'h5, 1'b0, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0);
        add_rst();

        for (int i = 0; i < tv.size(); i++)
            apply(tv[i]);

        // HLT at T3, then three full rings with everything gated off.
        cyc("hlt_T0", ph(0), 4'hF, 1'b0, 14'h0003, 1'b0, 1'b0);
        cyc("hlt_T1", ph(1), 4'hF, 1'b0, 14'h000C, 1'b0, 1'b0);
        cyc("hlt_T2", ph(2), 4'hF, 1'b0, 14'h0010, 1'b0, 1'b0);
        cyc("hlt_T3", ph(3), 4'hF, 1'b0, 14'h0000, 1'b1, 1'b0);
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 8; k++)
                cyc($sformatf("hlt_r%0d_T%0d", r, (k + 4) % 8), ph((k + 4) % 8), 4'h5, 1'b0,
                    14'h0000, 1'b1, 1'b0);
        apply('{"hlt_rst", 1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 1'b0});

`ifdef CTRL_STEP_EN
        // LDI ring then WAIT: two rings of silence without step.
        for (int k = 0; k < 8; k++)
            cyc($sformatf("st_ldi_T%0d", k), ph(k), 4'h5, 1'b0,
                (k == 0) ? 14'h0003 : (k == 1) ? 14'h000C : (k == 2) ? 14'h0010 :
                (k == 3) ? 14'h0060 : 14'h0000, 1'b0, 1'b0);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 8; k++)
                cyc($sformatf("st_wait%0d_T%0d", r, k), ph(k), 4'h5, 1'b0, 14'h0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            cyc($sformatf("st_arm_T%0d", k), ph(k), 4'h5, (k == 4), 14'h0, 1'b0, 1'b0);
        cyc("st_go_T0", ph(0), 4'h5, 1'b0, 14'h0003, 1'b0, 1'b0);
        cyc("st_go_T1", ph(1), 4'h5, 1'b0, 14'h000C, 1'b0, 1'b0);
        // Step during RUN is ignored; the following T0 stays in WAIT.
        for (int k = 2; k < 8; k++)
            cyc($sformatf("st_ign_T%0d", k), ph(k), 4'h5, (k == 2),
                (k == 2) ? 14'h0010 : (k == 3) ? 14'h0060 : 14'h0000, 1'b0, 1'b0);
        cyc("st_ign_T0", ph(0), 4'h5, 1'b0, 14'h0000, 1'b0, 1'b0);
        // Phase check still active in WAIT.
        cyc("st_wait_err", ph(3), 4'h5, 1'b0, 14'h0000, 1'b0, 1'b1);
`else
        // Back-to-back instructions: T0 after T7 fetches immediately.
        for (int k = 0; k < 8; k++)
            cyc($sformatf("b2b_T%0d", k), ph(k), 4'h5, 1'b0,
                (k == 0) ? 14'h0003 : (k == 1) ? 14'h000C : (k == 2) ? 14'h0010 :
                (k == 3) ? 14'h0060 : 14'h0000, 1'b0, 1'b0);
        cyc("b2b_T0b", ph(0), 4'h1, 1'b0, 14'h0003, 1'b0, 1'b0);
        cyc("b2b_T1b", ph(1), 4'h1, 1'b0, 14'h000C, 1'b0, 1'b0);
        cyc("b2b_T7err", ph(7), 4'h1, 1'b0, 14'h0000, 1'b0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Control sequencer for the 8-bit CPU model. It sits directly downstream of the ring-counter timing generator.
- It consumes the one-hot 8-phase timing vector, the IR opcode and the zero flag.
- It produces a registered 14-bit control word that drives the bus/register/ALU/RAM enables for each machine cycle.
- It also tracks run/halt/fault state and checks that the phase sequence is legal.

Parameters:
- CW_W, 14, control word width (fixed by the bit map below; must not be overridden).
- OPC_W, 4, opcode width (IR[7:4]).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- signals  in  8  one-hot phase vector from the timing generator.
- opcode  in  OPC_W  IR[7:4] as currently held in IR.
- zf  in  1  ALU zero flag.
- ctrl  out  CW_W  control word, registered.
- halted  out  1  HLT executed (sticky until rst).
- phase_err  out  1  illegal phase sequence (sticky until rst).
- illegal_op  out  1  one-cycle pulse when an undefined opcode is decoded.

Behaviour:
- Phase map: T0=signals[7] (timing generator reset phase), T1=bit0, T2=bit1, T3=bit2, T4=bit3, T5=bit4, T6=bit5, T7=bit6.
- Control word bits:
  - 0 pc_oe, 1 mar_ld, 2 ram_rd, 3 ir_ld, 4 pc_inc, 5 ir_oe (operand nibble to bus), 6 a_ld.
  - 7 b_ld, 8 alu_sub, 9 alu_oe, 10 ram_wr, 11 a_oe, 12 pc_ld, 13 out_ld.
- Latency: the control word for a phase observed in cycle c is on ctrl in cycle c+1. All outputs are registered.
- Reset (rst=1 at a posedge): ctrl=0, halted=0, phase_err=0, illegal_op=0, state=SYNC, op_q=0, prev_phase=0. Reset mid-instruction aborts it with no residual enables.
- States:
  - SYNC: ctrl=0. Leave on the first observed T0 and emit the T0 word.
  - RUN: emit microcode.
  - HALT: ctrl=0, halted=1.
  - FAULT: ctrl=0, phase_err=1.
  - HALT and FAULT exit only via rst.
- Phase check in RUN:
  - signals must be one-hot, and T(k) must follow T(k-1), with T0 following T7.
  - On violation: go to FAULT; that cycle's ctrl word is 0.
  - A zero or multi-hot vector counts as a violation in every state except SYNC, which just waits.
- Fetch:
  - T0: pc_oe|mar_ld.
  - T1: ram_rd|ir_ld.
  - T2: pc_inc.
  - T7: 0.
- Opcode handling: at T3 decode uses the opcode input directly and latches it into op_q. T4–T6 use op_q.
- Execute (steps not listed are 0):
  - NOP 0x0: nothing.
  - LDA 0x1: T3 ir_oe|mar_ld; T4 ram_rd|a_ld.
  - ADD 0x2: T3 ir_oe|mar_ld; T4 ram_rd|b_ld; T5 alu_oe|a_ld.
  - SUB 0x3: as ADD, but T5 adds alu_sub.
  - STA 0x4: T3 ir_oe|mar_ld; T4 a_oe|ram_wr.
  - LDI 0x5: T3 ir_oe|a_ld.
  - JMP 0x6: T3 ir_oe|pc_ld.
  - JZ 0x7: T3 ir_oe|pc_ld only if zf=1 when T3 is observed; otherwise 0.
  - OUT 0x8: T3 a_oe|out_ld.
  - HLT 0xF: T3 emits 0; next state HALT, so halted=1 from cycle c+1.
  - 0x9–0xE: treated as NOP, with illegal_op=1 for exactly the cycle after T3.
- Invariants: ram_rd and ram_wr are never both set. Exactly one bus driver (pc_oe/ir_oe/a_oe/alu_oe) at most per word.

Optional Feature:
- Macro: CTRL_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - After emitting the T7 word, the sequencer enters WAIT: ctrl=0, and phases are still checked.
  - A step=1 in any WAIT cycle arms the sequencer; the next observed T0 resumes RUN.
  - A step pulse outside WAIT is ignored.
  - rst clears the armed flag.
- Undefined: no step port, no WAIT state, instructions run back-to-back.

Decomposition:
- Shared package cpu8_pkg: opcode localparams, CW bit indices, phase-index constants (T0..T7 to bit position), state encoding.
- Sub-module ctrl_decode: combinational (phase index, opcode, zf) -> control word plus illegal flag.
- The top holds state, op_q, the phase checker and the output registers.

Test Plan:
- Reset, then T0..T7 with opcode=0x5 (LDI) -> ctrl sequence one cycle delayed: 0x0003, 0x000C, 0x0010, 0x0060, 0, 0, 0, 0.
- Opcode 0x3 (SUB) -> T5 word = 0x0340; T4 word = 0x0084.
- JZ with zf=1 at T3 -> T3 word 0x1020. Repeat with zf=0 -> T3 word 0x0000.
- HLT at T3 -> halted=1 on the next cycle; ctrl=0 thereafter across 3 full rings; cleared by rst.
- Inject T2 followed directly by T4, or signals=8'h00 mid-ring -> phase_err=1 and ctrl=0 until rst. Also opcode 0xA -> illegal_op pulse width 1.
- CTRL_STEP_EN: after T7 hold ctrl=0 for 2 rings without step. Pulse step during T4 -> the next T0 emits 0x0003.
